// File: rtl/generic_slave_spi_pkg.sv
// Shared encodings for the generic SPI slave: mode/bit-order values, FSM
// state constants and the latched per-frame configuration record.
package generic_slave_spi_pkg;

   localparam logic CPHA_SAMPLE_LEADING = 1'b0;
   localparam logic BIT_ORDER_MSB_FIRST = 1'b0;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic bit_order;
   } spi_cfg_t;

endpackage

// File: rtl/generic_slave_spi_if.sv
// Client/bus bundle of the SPI slave: mode straps, SCLK/SS/MOSI pins and
// the local TX load/ready and RX valid handshake.
interface generic_slave_spi_if #(
   parameter int WordLen = 8
);
   logic               CPOL;
   logic               CPHA;
   logic               BitOrder;
   logic               SCLK;
   logic               SS;
   logic               MOSI;
   logic [WordLen-1:0] SendData;
   logic               TxLoad;
   logic               TxReady;
   logic [WordLen-1:0] ReceivedData;
   logic               RxValid;
   logic               TxUnderrun;
   logic               Busy;

   modport slave (
      input  CPOL, CPHA, BitOrder, SCLK, SS, MOSI, SendData, TxLoad,
      output TxReady, ReceivedData, RxValid, TxUnderrun, Busy
   );

   modport master (
      output CPOL, CPHA, BitOrder, SCLK, SS, MOSI, SendData, TxLoad,
      input  TxReady, ReceivedData, RxValid, TxUnderrun, Busy
   );
endinterface

// File: rtl/generic_slave_spi_edge_sync.sv
// Synchronizes SCLK/SS/MOSI into clk and turns SCLK/SS transitions into
// registered single-cycle sample/shift and select/deselect pulses.
module spi_slave_edge_sync
   import generic_slave_spi_pkg::*;
#(
   parameter int SyncStages = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cpol,
   input  logic cpha,
   input  logic sclk,
   input  logic ss,
   input  logic mosi,
   output logic s_ss,
   output logic s_mosi,
   output logic sample_edge,
   output logic shift_edge,
   output logic ss_fall,
   output logic ss_rise
);

   logic [SyncStages-1:0] sclk_sync_r;
   logic [SyncStages-1:0] ss_sync_r;
   logic [SyncStages-1:0] mosi_sync_r;
   logic                  sclk_d_r;
   logic                  ss_d_r;
   logic                  s_ss_r;
   logic                  s_mosi_r;
   logic                  sample_edge_r;
   logic                  shift_edge_r;
   logic                  ss_fall_r;
   logic                  ss_rise_r;
   logic                  sclk_q_s;
   logic                  ss_q_s;
   logic                  leading_s;
   logic                  trailing_s;

   // Leading edge leaves the idle level, trailing edge returns to it.
   always_comb begin
      sclk_q_s   = sclk_sync_r[SyncStages-1];
      ss_q_s     = ss_sync_r[SyncStages-1];
      leading_s  = (sclk_q_s != cpol) && (sclk_d_r == cpol);
      trailing_s = (sclk_q_s == cpol) && (sclk_d_r != cpol);
   end

   // Synchronizer chains and pulse registers; SS idles deselected.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sync_r   <= '0;
         ss_sync_r     <= '1;
         mosi_sync_r   <= '0;
         sclk_d_r      <= 1'b0;
         ss_d_r        <= 1'b1;
         s_ss_r        <= 1'b1;
         s_mosi_r      <= 1'b0;
         sample_edge_r <= 1'b0;
         shift_edge_r  <= 1'b0;
         ss_fall_r     <= 1'b0;
         ss_rise_r     <= 1'b0;
      end else begin
         sclk_sync_r   <= {sclk_sync_r[SyncStages-2:0], sclk};
         ss_sync_r     <= {ss_sync_r[SyncStages-2:0], ss};
         mosi_sync_r   <= {mosi_sync_r[SyncStages-2:0], mosi};
         sclk_d_r      <= sclk_q_s;
         ss_d_r        <= ss_q_s;
         s_ss_r        <= ss_q_s;
         s_mosi_r      <= mosi_sync_r[SyncStages-1];
         sample_edge_r <= (cpha == CPHA_SAMPLE_LEADING) ? leading_s : trailing_s;
         shift_edge_r  <= (cpha == CPHA_SAMPLE_LEADING) ? trailing_s : leading_s;
         ss_fall_r     <= ss_d_r & ~ss_q_s;
         ss_rise_r     <= ~ss_d_r & ss_q_s;
      end
   end

   assign s_ss        = s_ss_r;
   assign s_mosi      = s_mosi_r;
   assign sample_edge = sample_edge_r;
   assign shift_edge  = shift_edge_r;
   assign ss_fall     = ss_fall_r;
   assign ss_rise     = ss_rise_r;

endmodule

// File: rtl/generic_slave_spi.sv
// SPI slave in the system clock domain: full-duplex WordLen-bit words per
// SS-low frame, runtime CPOL/CPHA/bit order, one-deep TX holding register.
module generic_slave_spi
   import generic_slave_spi_pkg::*;
#(
   parameter int WordLen    = 8,
   parameter int SyncStages = 2
) (
   input  logic                clk,
   input  logic                reset,
   generic_slave_spi_if.slave  bus,
   output wire                 MISO
);

   localparam int              CntW     = $clog2(WordLen + 1);
   localparam logic [CntW-1:0] CNT_FULL = CntW'(WordLen);
   localparam logic [CntW-1:0] CNT_ONE  = CntW'(1);

   logic               s_ss, s_mosi, sample_edge, shift_edge, ss_fall, ss_rise;
   spi_cfg_t           cfg_r, cfg_n;
   logic [0:0]         state_r, state_n;
   logic [CntW-1:0]    cnt_r, cnt_n;
   logic [WordLen-1:0] tx_shift_r, tx_shift_n;
   logic [WordLen-1:0] rx_shift_r, rx_shift_n;
   logic [WordLen-1:0] hold_r, hold_n;
   logic               hold_empty_r, hold_empty_n;
   logic [WordLen-1:0] rx_data_r, rx_data_n;
   logic               rx_valid_r, rx_valid_n;
   logic               underrun_r, underrun_n;
   logic               miso_r, miso_n;
   logic               miso_en_r, miso_en_n;
   logic               busy_r;
   logic               reload_s;
   logic               tx_accept_s;

   spi_slave_edge_sync #(
      .SyncStages (SyncStages)
   ) u_edge_sync (
      .clk         (clk),
      .reset       (reset),
      .cpol        (cfg_r.cpol),
      .cpha        (cfg_r.cpha),
      .sclk        (bus.SCLK),
      .ss          (bus.SS),
      .mosi        (bus.MOSI),
      .s_ss        (s_ss),
      .s_mosi      (s_mosi),
      .sample_edge (sample_edge),
      .shift_edge  (shift_edge),
      .ss_fall     (ss_fall),
      .ss_rise     (ss_rise)
   );

   // Next-state logic: frame FSM, bit counter, shifters and TX holding register.
   always_comb begin
      state_n    = state_r;
      cnt_n      = cnt_r;
      tx_shift_n = tx_shift_r;
      rx_shift_n = rx_shift_r;
      rx_data_n  = rx_data_r;
      rx_valid_n = 1'b0;
      underrun_n = 1'b0;
      reload_s   = 1'b0;
      cfg_n      = cfg_r;
      if (s_ss) begin
         cfg_n.cpol      = bus.CPOL;
         cfg_n.cpha      = bus.CPHA;
         cfg_n.bit_order = bus.BitOrder;
      end else begin
         cfg_n = cfg_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (ss_fall) begin
               reload_s = 1'b1;
               cnt_n    = '0;
               state_n  = ST_ACTIVE;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            // Deselect outranks any edge seen in the same cycle.
            if (ss_rise) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else if (sample_edge && (cnt_r != CNT_FULL)) begin
               rx_shift_n = (cfg_r.bit_order == BIT_ORDER_MSB_FIRST) ?
                            {rx_shift_r[WordLen-2:0], s_mosi} :
                            {s_mosi, rx_shift_r[WordLen-1:1]};
               cnt_n = cnt_r + CNT_ONE;
               if (cnt_n == CNT_FULL) begin
                  rx_data_n  = rx_shift_n;
                  rx_valid_n = 1'b1;
               end else begin
                  rx_valid_n = 1'b0;
               end
            end else if (shift_edge) begin
               // Count 0 is the first leading edge with CPHA=1: nothing to shift yet.
               if (cnt_r == CNT_FULL) begin
                  reload_s = 1'b1;
                  cnt_n    = '0;
               end else if (cnt_r != '0) begin
                  tx_shift_n = (cfg_r.bit_order == BIT_ORDER_MSB_FIRST) ?
                               {tx_shift_r[WordLen-2:0], 1'b0} :
                               {1'b0, tx_shift_r[WordLen-1:1]};
               end else begin
                  tx_shift_n = tx_shift_r;
               end
            end else begin
               state_n = ST_ACTIVE;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
      if (reload_s) begin
         tx_shift_n = hold_empty_r ? '0 : hold_r;
         underrun_n = hold_empty_r;
      end else begin
         underrun_n = 1'b0;
      end
      // A reload consumes the old content before a same-cycle load lands.
      tx_accept_s  = bus.TxLoad && hold_empty_r;
      hold_n       = tx_accept_s ? bus.SendData : hold_r;
      hold_empty_n = tx_accept_s ? 1'b0 : (reload_s ? 1'b1 : hold_empty_r);
      miso_n       = (cfg_r.bit_order == BIT_ORDER_MSB_FIRST) ?
                     tx_shift_n[WordLen-1] : tx_shift_n[0];
      miso_en_n    = (state_n == ST_ACTIVE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_r        <= '0;
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         tx_shift_r   <= '0;
         rx_shift_r   <= '0;
         hold_r       <= '0;
         hold_empty_r <= 1'b1;
         rx_data_r    <= '0;
         rx_valid_r   <= 1'b0;
         underrun_r   <= 1'b0;
         miso_r       <= 1'b0;
         miso_en_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         cfg_r        <= cfg_n;
         state_r      <= state_n;
         cnt_r        <= cnt_n;
         tx_shift_r   <= tx_shift_n;
         rx_shift_r   <= rx_shift_n;
         hold_r       <= hold_n;
         hold_empty_r <= hold_empty_n;
         rx_data_r    <= rx_data_n;
         rx_valid_r   <= rx_valid_n;
         underrun_r   <= underrun_n;
         miso_r       <= miso_n;
         miso_en_r    <= miso_en_n;
         busy_r       <= ~s_ss;
      end
   end

   assign bus.TxReady      = hold_empty_r;
   assign bus.ReceivedData = rx_data_r;
   assign bus.RxValid      = rx_valid_r;
   assign bus.TxUnderrun   = underrun_r;
   assign bus.Busy         = busy_r;
   // MISO is kept outside the bundle so the tristate driver sits at the pin.
   assign MISO             = miso_en_r ? miso_r : 1'bz;

endmodule

// File: tb/tb_generic_slave_spi.sv
// Directed plus randomized frames for generic_slave_spi, checked against a
// word-level model of the holding register, underruns and received words.
module tb_generic_slave_spi;

   localparam int W = 8;
   localparam int H = 10;

   logic clk = 1'b0;
   logic reset;
   wire  miso;

   generic_slave_spi_if #(.WordLen(W)) bus ();

   generic_slave_spi #(.WordLen(W), .SyncStages(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .MISO  (miso)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   int         rx_cnt = 0;
   int         un_cnt = 0;
   logic [W-1:0] last_rx = '0;

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (bus.RxValid) begin
            rx_cnt  = rx_cnt + 1;
            last_rx = bus.ReceivedData;
         end
         if (bus.TxUnderrun) un_cnt = un_cnt + 1;
      end
   end

   // Word-level model of the TX holding register.
   logic         m_full = 1'b0;
   logic [W-1:0] m_hold = '0;
   int           m_under = 0;

   logic [W-1:0] mosi_w [2];
   logic [W-1:0] miso_w [2];
   logic [W-1:0] exp_tx [2];

   function automatic logic [W-1:0] take_hold();
      if (m_full) begin
         m_full = 1'b0;
         return m_hold;
      end
      m_under = m_under + 1;
      return '0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_load(input logic [W-1:0] v);
      @(negedge clk);
      bus.SendData = v;
      bus.TxLoad   = 1'b1;
      @(negedge clk);
      bus.TxLoad   = 1'b0;
      if (!m_full) begin
         m_full = 1'b1;
         m_hold = v;
      end
   endtask

   task automatic frame(input logic cpol, input logic cpha, input logic order,
                        input int nbits, input logic mid_en, input logic [W-1:0] mid_val,
                        input logic cpol_glitch);
      int rx0, un0, mu0, full, w, b, idx;
      logic [W-1:0] t;
      bus.CPOL = cpol; bus.CPHA = cpha; bus.BitOrder = order; bus.SCLK = cpol;
      wait_clks(10);
      rx0 = rx_cnt; un0 = un_cnt; mu0 = m_under;
      bus.SS = 1'b0;
      exp_tx[0] = take_hold();
      wait_clks(10);
      check("tx_ready_after_fall", bus.TxReady, !m_full);
      check("busy_active", bus.Busy, 1);
      if (cpol_glitch) bus.CPOL = ~cpol;
      for (int k = 0; k < nbits; k++) begin
         w = k / W; b = k % W;
         idx = order ? b : W - 1 - b;
         if (mid_en && w == 0 && b == 3) tx_load(mid_val);
         if (!cpha) begin
            bus.MOSI = mosi_w[w][idx];
            wait_clks(H);
            miso_w[w][idx] = miso;
            bus.SCLK = ~cpol;
            wait_clks(H);
            bus.SCLK = cpol;
            if (b == W - 1) begin
               t = take_hold();
               if (w == 0) exp_tx[1] = t;
            end
         end else begin
            if (w > 0 && b == 0) exp_tx[w] = take_hold();
            bus.SCLK = ~cpol;
            bus.MOSI = mosi_w[w][idx];
            wait_clks(H);
            miso_w[w][idx] = miso;
            bus.SCLK = cpol;
            wait_clks(H);
         end
      end
      wait_clks(H);
      bus.SS = 1'b1;
      wait_clks(10);
      bus.CPOL = cpol;
      full = nbits / W;
      for (int i = 0; i < full; i++) check("miso_word", miso_w[i], exp_tx[i]);
      check("rx_count", rx_cnt - rx0, full);
      if (full > 0) check("rx_data", last_rx, mosi_w[full-1]);
      check("underruns", un_cnt - un0, m_under - mu0);
      check("tx_ready_end", bus.TxReady, !m_full);
      check("busy_idle", bus.Busy, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   logic         r_cpol, r_cpha, r_order, r_mid;
   int           r_nbits;
   logic [W-1:0] r_val;

   initial begin
      bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.BitOrder = 1'b0;
      bus.SCLK = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b0;
      bus.SendData = '0; bus.TxLoad = 1'b0;
      reset = 1'b0;
      wait_clks(3);
      check("rst_tx_ready", bus.TxReady, 1);
      check("rst_rx_valid", bus.RxValid, 0);
      check("rst_underrun", bus.TxUnderrun, 0);
      check("rst_rx_data", bus.ReceivedData, 0);
      check("rst_busy", bus.Busy, 0);
      reset = 1'b1;
      wait_clks(5);

      // Mode 0 MSB first: 0xA5 out, 0x3C in.
      tx_load(8'hA5);
      check("tx_ready_loaded", bus.TxReady, 0);
      mosi_w[0] = 8'h3C;
      frame(1'b0, 1'b0, 1'b0, 8, 1'b0, 8'h00, 1'b0);

      // Mode 3 LSB first: 0x81 out, 0x7E in.
      tx_load(8'h81);
      mosi_w[0] = 8'h7E;
      frame(1'b1, 1'b1, 1'b1, 8, 1'b0, 8'h00, 1'b0);

      // Mode 1 back-to-back, second word loaded mid-frame.
      tx_load(8'h11);
      mosi_w[0] = 8'hC3; mosi_w[1] = 8'h96;
      frame(1'b0, 1'b1, 1'b0, 16, 1'b1, 8'h22, 1'b0);

      // Empty holding register at frame start.
      mosi_w[0] = 8'h69;
      frame(1'b1, 1'b0, 1'b0, 8, 1'b0, 8'h00, 1'b0);

      // Deselect after 5 bits, then a full frame.
      tx_load(8'hF0);
      mosi_w[0] = 8'hFF;
      frame(1'b0, 1'b0, 1'b0, 5, 1'b0, 8'h00, 1'b0);
      tx_load(8'h3C);
      mosi_w[0] = 8'h5A;
      frame(1'b0, 1'b0, 1'b0, 8, 1'b0, 8'h00, 1'b0);

      // CPOL toggled inside a frame is ignored; next frame uses the new mode.
      tx_load(8'h6B);
      mosi_w[0] = 8'hD2;
      frame(1'b0, 1'b1, 1'b1, 8, 1'b0, 8'h00, 1'b1);
      tx_load(8'h4E);
      mosi_w[0] = 8'h1F;
      frame(1'b1, 1'b0, 1'b0, 8, 1'b0, 8'h00, 1'b0);

      // Reset asserted mid-frame.
      bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.SCLK = 1'b0;
      wait_clks(10);
      tx_load(8'h77);
      bus.SS = 1'b0;
      wait_clks(10);
      bus.SCLK = 1'b1; wait_clks(H);
      bus.SCLK = 1'b0; wait_clks(H);
      #2 reset = 1'b0;
      #1;
      check("midrst_tx_ready", bus.TxReady, 1);
      check("midrst_rx_valid", bus.RxValid, 0);
      check("midrst_underrun", bus.TxUnderrun, 0);
      check("midrst_rx_data", bus.ReceivedData, 0);
      check("midrst_busy", bus.Busy, 0);
      bus.SS = 1'b1;
      m_full = 1'b0;
      wait_clks(5);
      reset = 1'b1;
      wait_clks(5);

      // Randomized frames.
      for (int n = 0; n < 14; n++) begin
         r_cpol  = 1'($urandom_range(1, 0));
         r_cpha  = 1'($urandom_range(1, 0));
         r_order = 1'($urandom_range(1, 0));
         r_val   = W'($urandom);
         if ($urandom_range(1, 0) == 1) tx_load(r_val);
         mosi_w[0] = W'($urandom);
         mosi_w[1] = W'($urandom);
         r_nbits = W * int'($urandom_range(2, 1));
         if ($urandom_range(3, 0) == 0) r_nbits = int'($urandom_range(7, 1));
         r_mid = (r_nbits > W) ? 1'($urandom_range(1, 0)) : 1'b0;
         frame(r_cpol, r_cpha, r_order, r_nbits, r_mid, W'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
